// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the main-memory bus initiator.
// Holds the state encoding, operation codes, word stride and matrix base addresses.
package mem_bus_pkg;

   typedef enum logic [3:0] {
      IDLE,
      RD_SETUP,
      RD_STROBE,
      RD_GAP,
      WR_FETCH,
      WR_SETUP,
      WR_STROBE,
      WR_HOLD,
      DONE
   } mem_state_e;

   localparam logic MEM_OP_READ  = 1'b0;
   localparam logic MEM_OP_WRITE = 1'b1;

   localparam int WORD_STRIDE = 4;

   localparam logic [31:0] MAT_A_BASE = 32'h0000_0200;
   localparam logic [31:0] MAT_B_BASE = 32'h0000_0300;
   localparam logic [31:0] MAT_C_BASE = 32'h0000_0100;

   // A request is legal when it moves 1..max_burst words from a word-aligned base.
   function automatic logic req_legal(input logic [3:0] len,
                                      input logic [1:0] addr_lsb,
                                      input int         max_burst);
      return (len != 4'd0) && (int'(len) <= max_burst) && (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times how long a memory strobe stays high.
// last is asserted while the count sits at zero, i.e. on the final strobe cycle.
module mem_wait_counter #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] count,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= count;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_burst_initiator.sv
// Initiator side of the main-memory bus: single-word and burst reads/writes at word stride.
// Address and write data only move while both strobes are low, so the level-sensitive memory sees stable values.
module mem_burst_initiator
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_BURST   = 9,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [3:0]        len,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              memread,
   output logic              memwrite,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] data_out
);

   localparam int WC_W  = $clog2(MAX_BURST + 1);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wd_q;
   logic [DATA_W-1:0] rd_q;
   logic [3:0]        len_q;
   logic [WC_W-1:0]   word_q;
   logic              busy_q;
   logic              err_q;
   logic              accept;
   logic              reject;
   logic              wait_load;
   logic              wait_last;
   logic              last_word;

   mem_wait_counter #(
      .CNT_W (CNT_W)
   ) u_wait (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (wait_load),
      .count (CNT_W'(WAIT_CYCLES - 1)),
      .last  (wait_last)
   );

   assign last_word = ((int'(word_q) + 1) == int'(len_q));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      reject      = 1'b0;
      wait_load   = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      rdata_valid = 1'b0;
      wdata_ready = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (req_legal(len, base_addr[1:0], MAX_BURST)) begin
                  accept  = 1'b1;
                  state_d = (rw == MEM_OP_WRITE) ? WR_FETCH : RD_SETUP;
               end else begin
                  reject  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         RD_SETUP: begin
            wait_load = 1'b1;
            state_d   = RD_STROBE;
         end
         RD_STROBE: begin
            memread = 1'b1;
            if (wait_last) state_d = RD_GAP;
         end
         RD_GAP: begin
            rdata_valid = 1'b1;
            state_d     = last_word ? DONE : RD_SETUP;
         end
         WR_FETCH: begin
            wdata_ready = 1'b1;
            if (wdata_valid) state_d = WR_SETUP;
         end
         WR_SETUP: begin
            wait_load = 1'b1;
            state_d   = WR_STROBE;
         end
         WR_STROBE: begin
            memwrite = 1'b1;
            if (wait_last) state_d = WR_HOLD;
         end
         WR_HOLD: begin
            state_d = last_word ? DONE : WR_FETCH;
         end
         DONE: begin
            done    = 1'b1;
            err     = err_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Address steps only in RD_GAP / WR_HOLD, where both strobes are already low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= '0;
         wd_q   <= '0;
         rd_q   <= '0;
         len_q  <= '0;
         word_q <= '0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            addr_q <= base_addr;
            len_q  <= len;
            word_q <= '0;
            busy_q <= 1'b1;
            err_q  <= 1'b0;
         end
         if (reject) err_q <= 1'b1;
         if (state_q == DONE) busy_q <= 1'b0;
         if ((state_q == RD_STROBE) && wait_last) rd_q <= data_out;
         if ((state_q == WR_FETCH) && wdata_valid) wd_q <= wdata;
         if (((state_q == RD_GAP) || (state_q == WR_HOLD)) && !last_word) begin
            addr_q <= addr_q + ADDR_W'(WORD_STRIDE);
            word_q <= word_q + WC_W'(1);
         end
      end
   end

   assign address = addr_q;
   assign data_in = wd_q;
   assign rdata   = rd_q;
   assign busy    = busy_q;

endmodule
